// File: rtl/hmmm_pkg.sv
// Shared constants for the sequential ALU front-end: data width, op codes and FSM states.
package hmmm_pkg;

    localparam int WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_MUL      = 2'd2,
        ST_FIX      = 2'd3
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational downstream ALU: add/sub with signed-overflow carry, plus simple logic ops.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);
    import hmmm_pkg::*;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        if (en) begin
            case (op)
                OP_ADD: begin
                    result = a + b;
                    carry  = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB: begin
                    result = a - b;
                    carry  = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
                end
                3'd3:    result = a & b;
                3'd4:    result = a | b;
                3'd5:    result = a ^ b;
                default: result = a;
            endcase
        end
        zero = en && (result == '0);
    end

endmodule

// File: rtl/alu_seq_mul.sv
// Iterative shift-add magnitude multiplier; the sign is applied later by the owner's FIX step.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               last,
    output logic               sign,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic                run_q, run_d;
    logic                sign_q, sign_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [2*WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;

    // Most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign last = run_q && (cnt_q == CNT_W'(WIDTH-1));

    always_comb begin
        run_d    = run_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            run_d    = 1'b1;
            sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mag(a)};
            mplier_d = mag(b);
        end else if (run_q) begin
            if (mplier_q[0])
                acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last)
                run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            run_q    <= run_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign busy    = run_q;
    assign sign    = sign_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequencer in front of a combinational ALU: single-cycle dispatch for ALU ops,
// 16-step internal multiply for MUL_OP, registered result and flags.
module alu_seq #(
    parameter int         WIDTH  = hmmm_pkg::WIDTH,
    parameter logic [2:0] MUL_OP = hmmm_pkg::OP_MUL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic [WIDTH-1:0] alu_tmp1,
    output logic [WIDTH-1:0] alu_tmp2,
    output logic [2:0]       alu_op,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry
);
    import hmmm_pkg::*;

    state_e             state_q, state_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zf_q, zf_d;
    logic               cf_q, cf_d;
    logic [WIDTH-1:0]   tmp1_q, tmp1_d;
    logic [WIDTH-1:0]   tmp2_q, tmp2_d;
    logic [2:0]         op_q, op_d;

    logic               mul_start, mul_busy, mul_last, mul_sign;
    logic [2*WIDTH-1:0] mul_product, fix_prod;
    logic [WIDTH:0]     fix_upper;

    assign mul_start = (state_q == ST_IDLE) && start && (op == MUL_OP);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .last    (mul_last),
        .sign    (mul_sign),
        .product (mul_product)
    );

    // Magnitude is zero for any zero operand, so negation never yields a negative zero.
    assign fix_prod  = mul_sign ? -mul_product : mul_product;
    assign fix_upper = fix_prod[2*WIDTH-1:WIDTH-1];

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        result_d = result_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        tmp1_d   = tmp1_q;
        tmp2_d   = tmp2_q;
        op_d     = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tmp1_d  = a;
                    tmp2_d  = b;
                    op_d    = op;
                    state_d = (op == MUL_OP) ? ST_MUL : ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                result_d = alu_result;
                zf_d     = alu_zero;
                cf_d     = alu_carry;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_MUL: begin
                if (mul_last || !mul_busy)
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                result_d = fix_prod[WIDTH-1:0];
                zf_d     = (fix_prod[WIDTH-1:0] == '0);
                cf_d     = !((&fix_upper) || !(|fix_upper));
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            tmp1_q   <= '0;
            tmp2_q   <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            tmp1_q   <= tmp1_d;
            tmp2_q   <= tmp2_d;
            op_q     <= op_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign result     = result_q;
    assign zero_flag  = zf_q;
    assign carry_flag = cf_q;
    assign alu_tmp1   = tmp1_q;
    assign alu_tmp2   = tmp2_q;
    assign alu_op     = op_q;
    assign alu_enable = (state_q == ST_DISPATCH);

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq paired with the alu; expectations come from integer arithmetic.
module tb_alu_seq;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [W-1:0]  a = '0, b = '0;
    logic          busy, done, zero_flag, carry_flag, alu_enable, alu_zero, alu_carry;
    logic [W-1:0]  result, alu_tmp1, alu_tmp2, alu_result;
    logic [2:0]    alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .alu_tmp1(alu_tmp1), .alu_tmp2(alu_tmp2),
        .alu_op(alu_op), .alu_enable(alu_enable), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_carry(alu_carry)
    );

    alu u_alu (
        .en(alu_enable), .op(alu_op), .a(alu_tmp1), .b(alu_tmp2),
        .result(alu_result), .zero(alu_zero), .carry(alu_carry)
    );

    // Reference: exact integer result, truncated; carry means it does not fit in 16-bit signed.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic z, output logic c);
        int sx, sy, s;
        sx = int'($signed(x));
        sy = int'($signed(y));
        case (o)
            3'd0:    s = sx + sy;
            3'd1:    s = sx - sy;
            default: s = sx * sy;
        endcase
        r = s[W-1:0];
        z = (r == '0);
        c = (s < -32768) || (s > 32767);
    endfunction

    // Issue one request now; return the done latency in edges after the accept edge (-1 on timeout).
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int busy_cyc, output bit en_seen, output bit early_done);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
        busy_cyc   = busy ? 1 : 0;
        early_done = done;
        en_seen    = (o == 3'd2) && alu_enable;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (busy) busy_cyc++;
            if (o == 3'd2 && alu_enable) en_seen = 1'b1;
            if (done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, zero_flag, carry_flag, alu_enable} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, zero_flag, carry_flag, alu_enable});
        end
        checks++;
        if ({result, alu_tmp1, alu_tmp2, alu_op} !== '0) begin
            errors++; $display("FAIL reset_data: got result=%h tmp1=%h tmp2=%h op=%0d expected all 0", result, alu_tmp1, alu_tmp2, alu_op);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat, bc; bit en, ed;
        run_op(3'd0, 16'hFFFF, 16'd1, lat, bc, en, ed);
        checks++;
        if (lat !== 1 || bc !== 1 || ed !== 1'b0) begin
            errors++; $display("FAIL add_timing: got lat=%0d busy=%0d early=%0d expected 1 1 0", lat, bc, ed);
        end
        checks++;
        if ({result, zero_flag, carry_flag} !== {16'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add_m1_p1: got r=%0d z=%0d c=%0d expected 0 1 0", $signed(result), zero_flag, carry_flag);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL add_done_width: got done=%0d expected 0", done);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({result, zero_flag} !== {16'd0, 1'b1}) begin
            errors++; $display("FAIL add_hold: got r=%0d z=%0d expected 0 1", $signed(result), zero_flag);
        end
        run_op(3'd0, 16'd32767, 16'd2, lat, bc, en, ed);
        checks++;
        if ({result, zero_flag, carry_flag} !== {16'h8001, 1'b0, 1'b1}) begin
            errors++; $display("FAIL add_ovf: got r=%h z=%0d c=%0d expected 8001 0 1", result, zero_flag, carry_flag);
        end
        @(posedge clk); #1;
        run_op(3'd1, 16'd5, 16'd2, lat, bc, en, ed);
        checks++;
        if (lat !== 1 || {result, zero_flag, carry_flag} !== {16'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sub_5_2: got lat=%0d r=%0d z=%0d c=%0d expected 1 3 0 0", lat, $signed(result), zero_flag, carry_flag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int lat, bc; bit en, ed;
        logic [W-1:0] xs [4] = '{16'd3, 16'd256, 16'h8000, 16'd0};
        logic [W-1:0] ys [4] = '{16'hFFFB, 16'd256, 16'd1, 16'hFFF9};
        logic [W-1:0] rs [4] = '{16'hFFF1, 16'd0, 16'h8000, 16'd0};
        logic [1:0]   fl [4] = '{2'b00, 2'b11, 2'b00, 2'b10};
        for (int i = 0; i < 4; i++) begin
            run_op(3'd2, xs[i], ys[i], lat, bc, en, ed);
            checks++;
            if (lat !== 17 || bc !== 17 || en !== 1'b0) begin
                errors++; $display("FAIL mul_timing[%0d]: got lat=%0d busy=%0d en=%0d expected 17 17 0", i, lat, bc, en);
            end
            checks++;
            if ({result, zero_flag, carry_flag} !== {rs[i], fl[i]}) begin
                errors++; $display("FAIL mul_value[%0d]: got r=%h z=%0d c=%0d expected %h %b", i, result, zero_flag, carry_flag, rs[i], fl[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1, dones = 0;
        logic [W-1:0] res = '0;
        start = 1'b1; op = 3'd2; a = 16'd3; b = 16'hFFFB;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 3'd0; a = 16'd100; b = 16'd100;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({alu_tmp1, alu_tmp2, alu_op} !== {16'd3, 16'hFFFB, 3'd2}) begin
            errors++; $display("FAIL ignore_latch: got tmp1=%h tmp2=%h op=%0d expected 0003 fffb 2", alu_tmp1, alu_tmp2, alu_op);
        end
        for (int k = 6; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (lat < 0) begin lat = k; res = result; end
            end
        end
        checks++;
        if (dones !== 1 || lat !== 17 || res !== 16'hFFF1) begin
            errors++; $display("FAIL ignore_start: got dones=%0d lat=%0d r=%h expected 1 17 fff1", dones, lat, res);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, dones = 0; bit en, ed;
        start = 1'b1; op = 3'd2; a = 16'd1234; b = 16'hFFB3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({busy, done, zero_flag, carry_flag, alu_enable, result, alu_tmp1, alu_tmp2, alu_op} !== '0) begin
            errors++; $display("FAIL reset_mid: got busy=%0d done=%0d r=%h tmp1=%h tmp2=%h op=%0d expected all 0",
                               busy, done, result, alu_tmp1, alu_tmp2, alu_op);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL reset_no_done: got %0d active cycles expected 0", dones);
        end
        run_op(3'd0, 16'd100, 16'hFFE2, lat, bc, en, ed);
        checks++;
        if (lat !== 1 || {result, zero_flag, carry_flag} !== {16'd70, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_then_add: got lat=%0d r=%0d expected 1 70", lat, $signed(result));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit en, ed;
        logic [2:0]   os [3] = '{3'd2, 3'd0, 3'd2};
        logic [W-1:0] xs [3] = '{16'd7, 16'd10, 16'hFFFD};
        logic [W-1:0] ys [3] = '{16'd9, 16'd20, 16'hFFFD};
        logic [W-1:0] r; logic z, c;
        for (int i = 0; i < 3; i++) begin
            run_op(os[i], xs[i], ys[i], lat, bc, en, ed);
            model(os[i], xs[i], ys[i], r, z, c);
            checks++;
            if (ed !== 1'b0 || lat !== ((os[i] == 3'd2) ? 17 : 1) || {result, zero_flag, carry_flag} !== {r, z, c}) begin
                errors++; $display("FAIL b2b[%0d]: got early=%0d lat=%0d r=%h z=%0d c=%0d expected 0 - %h %0d %0d",
                                   i, ed, lat, result, zero_flag, carry_flag, r, z, c);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, bc; bit en, ed;
        logic [W-1:0] sp [4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};
        logic [W-1:0] x, y, r; logic [2:0] o; logic z, c;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 2));
            x = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : W'($urandom);
            y = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : W'($urandom);
            model(o, x, y, r, z, c);
            run_op(o, x, y, lat, bc, en, ed);
            checks++;
            if (lat !== ((o == 3'd2) ? 17 : 1) || en !== 1'b0 || ed !== 1'b0) begin
                errors++; $display("FAIL rand_timing[%0d]: op=%0d got lat=%0d en=%0d early=%0d", i, o, lat, en, ed);
            end
            checks++;
            if ({result, zero_flag, carry_flag} !== {r, z, c}) begin
                errors++; $display("FAIL rand_value[%0d]: op=%0d a=%h b=%h got %h z=%0d c=%0d expected %h z=%0d c=%0d",
                                   i, o, x, y, result, zero_flag, carry_flag, r, z, c);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL rand_done_width[%0d]: got done=%0d expected 0", i, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter MUL_OP, default 3'd2: op code executed internally as a multiply.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 start  in  1  request strobe, sampled only in IDLE.
REQ-006 op  in  3  operation code.
REQ-007 a, b  in  WIDTH each  signed operands.
REQ-008 busy  out  1  high whenever the state is not IDLE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 result  out  WIDTH  signed registered result.
REQ-011 zero_flag, carry_flag  out  1 each  registered flags of the last completed operation.
REQ-012 alu_tmp1, alu_tmp2  out  WIDTH each  operands to the downstream ALU.
REQ-013 alu_op  out  3  op to the ALU; alu_enable  out  1  ALU enable.
REQ-014 alu_result  in  WIDTH; alu_zero, alu_carry  in  1 each  combinational ALU outputs.

Function
REQ-015 FSM states SHALL be IDLE, DISPATCH, MUL and FIX, with IDLE as the reset state.
REQ-016 IDLE with start=1 at edge E SHALL latch a, b and op, then go to MUL if op==MUL_OP, else to DISPATCH.
REQ-017 start while busy=1 SHALL be ignored, with no change to any latched operand.
REQ-018 alu_tmp1, alu_tmp2 and alu_op SHALL be driven from the latched registers at all times.
REQ-019 alu_enable SHALL be high only in DISPATCH.
REQ-020 DISPATCH SHALL last one cycle; at edge E+1: result<=alu_result, zero_flag<=alu_zero, carry_flag<=alu_carry, done<=1, next state IDLE.
REQ-021 MUL path, at edge E: latch |a| and |b| as WIDTH-bit unsigned (|-32768| = 32768), latch sign = a[15]^b[15], clear the 2*WIDTH accumulator and the 4-bit iteration counter.
REQ-022 MUL SHALL run one shift-add iteration per edge, E+1 through E+16, then go to FIX.
REQ-023 FIX at edge E+17: negate the product if sign=1, set result to the low WIDTH bits, set zero_flag = (low bits==0), set done<=1, next state IDLE.
REQ-024 carry_flag after FIX SHALL be 1 if the signed 32-bit product lies outside -32768..32767, else 0.
REQ-025 A zero operand SHALL give result 0, zero_flag 1 and carry_flag 0; a 0 × negative product SHALL NOT produce negative zero.
REQ-026 done SHALL be high for exactly one cycle per accepted request.
REQ-027 result and flags SHALL hold their values until the next completion.
REQ-028 A start sampled in the same cycle that done is high SHALL be accepted, since the state is then IDLE; back-to-back operations are legal.
REQ-029 alu_enable SHALL never be asserted during a multiply.

Reset
REQ-030 rst_n=0 at an edge, including mid-MUL or mid-DISPATCH, SHALL force:
- state IDLE, done=0 and busy=0;
- result=0, zero_flag=0, carry_flag=0;
- alu_tmp1=0, alu_tmp2=0, alu_op=0, alu_enable=0;
- accumulator and counter cleared.
REQ-031 No done pulse SHALL be generated for an operation aborted by reset.

Structure
REQ-032 The shared package hmmm_pkg SHALL hold WIDTH, the ALU op-code constants (ADD=0, SUB=1, MUL=2) and the FSM state enumeration.
REQ-033 The iterative multiplier datapath SHALL be one sub-module, alu_seq_mul (start, operands, busy, product); the FSM and ALU interface SHALL stay in alu_seq.

Verification
REQ-034 Bench SHALL instantiate alu_seq together with the real alu.
REQ-035 Add: a=-1, b=1, op=0 -> done one cycle after the accept edge, result=0, zero_flag=1, carry_flag=0.
REQ-036 Overflow add: a=32767, b=2, op=0 -> carry_flag=1; sub a=5, b=2, op=1 -> result=3, carry_flag=0.
REQ-037 Multiply: a=3, b=-5, op=2 -> busy for 17 cycles, done at edge E+17, result=-15, zero_flag=0, carry_flag=0; alu_enable stays 0 throughout.
REQ-038 Multiply overflow: a=256, b=256 -> result=0, zero_flag=1, carry_flag=1; a=-32768, b=1 -> result=-32768, carry_flag=0.
REQ-039 Start at edge E+5 of a multiply with new operands -> ignored; the original product is reported and exactly one done pulse occurs.
REQ-040 rst_n=0 at edge E+8 of a multiply -> all outputs 0 and busy=0 on the next cycle, no done pulse; a following add completes normally.
